junction_safety_monitor: RTL and testbench
==========================================

Name: junction_safety_monitor

Overview:
- Conflict/sequence monitor directly downstream of the 3-way junction controller; sits between the controller's R/A/G outputs and the lamp drivers.
- In NORMAL it passes the 18 lamp signals through one register.
- On any unsafe pattern it latches a fault code and forces all-red flashing (fail-safe) until the fault is cleared under all-red conditions.

Parameters:
- N_HEADS, 6, number of signal heads (head i = controller signals R(i+1)/A(i+1)/G(i+1)).
- CONFLICT, 36'h3CFCF3F3C, conflict matrix; row i at bits [6i+5:6i]; bit j=1 means heads i and j must not both be non-red. Default pairs compatible: 0/1, 2/3, 4/5.
- MIN_AMBER, 4, minimum consecutive amber cycles before A->R.
- FLASH_HALF, 8, cycles per half-period of the fault red flash.
- ALLRED_CLEAR, 4, consecutive all-red input cycles required before a clear is accepted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- r_in  in  N_HEADS  red lamps from controller, bit i = head i
- a_in  in  N_HEADS  amber lamps from controller
- g_in  in  N_HEADS  green lamps from controller
- clear_fault  in  1  single-cycle fault clear request
- r_out  out  N_HEADS  red lamp drive
- a_out  out  N_HEADS  amber lamp drive
- g_out  out  N_HEADS  green lamp drive
- fault  out  1  high while in FAULT
- fault_code  out  3  latched fault cause
- fault_head  out  3  lowest-index head involved in the latched fault

Behaviour:
- Reset (rst high at posedge): r_out=6'h3F, a_out=g_out=0, fault=0, fault_code=0, fault_head=0, state=NORMAL, prev-lamp register=all-red, all counters=0. Reset overrides every other input, including mid-flash.
- States: NORMAL, FAULT.
- NORMAL, no fault detected this cycle: r/a/g_out <= r/a/g_in (1-cycle latency); prev <= inputs.
- Checks are evaluated combinationally on the current inputs against prev. On a fault edge, outputs load r_out=3F, a_out=g_out=0 and fault=1 directly. The faulty pattern never reaches the outputs.
- Fault codes, in priority order (lowest number wins if several occur in the same cycle): 0 NONE; 1 CONFLICT; 2 ILLEGAL; 3 SEQ; 4 AMBER_SHORT.
  - CONFLICT: any i,j with CONFLICT[i][j]=1 and both heads non-red (A or G lit).
  - ILLEGAL: a head's {r,a,g} is not one-hot (dark or multiple lamps lit).
  - SEQ: a transition other than R->G, G->A, A->R or hold.
  - AMBER_SHORT: A->R after fewer than MIN_AMBER amber cycles.
- fault_head = lowest head index implicated by the winning code (for CONFLICT, the lower of the pair).
- Amber counter per head: cleared whenever the head is not amber; increments each amber cycle; saturates at MIN_AMBER. The first amber cycle counts as 1. A->R is legal iff count==MIN_AMBER on the last amber cycle.
- FAULT:
  - Inputs are not checked.
  - a_out=g_out=0.
  - r_out starts at 3F on entry and toggles between 3F and 00 every FLASH_HALF cycles.
  - fault_code and fault_head hold.
  - allred_cnt counts consecutive cycles with r_in=3F, a_in=g_in=0; it saturates at ALLRED_CLEAR and clears on any other input pattern.
- Exit FAULT: clear_fault=1 while allred_cnt==ALLRED_CLEAR.
  - Next edge: state=NORMAL, fault=0, fault_code=0, fault_head=0, r_out=3F, a/g_out=0, prev=all-red, amber counters=0.
  - Pass-through resumes from the following cycle.
  - A clear_fault pulse under any other condition is ignored and is not remembered.
- Counter widths: $clog2(max value + 1).

Decomposition:
- Package traffic_pkg: N_HEADS; fault_code_e enum (NONE, CONFLICT, ILLEGAL, SEQ, AMBER_SHORT); lamp_e {RED, AMBER, GREEN}; DEFAULT_CONFLICT constant.
- Sub-module head_seq_checker, instantiated N_HEADS times. It holds the per-head amber counter and the one-hot/transition check, and outputs illegal, seq_err, amber_short and non_red.
- The top level holds the conflict matrix reduction, priority encoder, FSM, flash timer and output registers.

Test Plan:
- Legal cycle on head 0 (G 5 cycles, A 4, R) with head 1 mirroring and others red -> outputs equal inputs delayed 1 cycle; fault stays 0.
- Heads 0 and 2 green together -> on that edge r_out=3F, a_out=g_out=0, fault=1, fault_code=1, fault_head=0; the green pattern never appears on g_out.
- Head 4 amber for 3 cycles then red -> fault_code=4, fault_head=4. Repeat with 4 amber cycles -> no fault.
- Head 3 G->R directly -> fault_code=3, fault_head=3. Then r_out toggles 3F/00 every 8 cycles.
- In FAULT, clear_fault pulsed after 2 all-red cycles -> ignored. Pulsed after 4 all-red cycles -> fault=0 and code=0 next cycle, pass-through resumes.
- rst asserted mid-flash while r_out=00 -> next edge r_out=3F, fault=0, state NORMAL; a subsequent R->G on head 0 is accepted.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and constants for the 3-way junction lamp path: head count,
// default conflict matrix, fault codes, lamp colours and monitor states.
package traffic_pkg;

   localparam int N_HEADS = 6;

   // Row i at bits [6i+5:6i]; compatible pairs are 0/1, 2/3 and 4/5.
   localparam logic [N_HEADS*N_HEADS-1:0] DEFAULT_CONFLICT = 36'h3CFCF3F3C;

   typedef enum logic [2:0] {
      FC_NONE        = 3'd0,
      FC_CONFLICT    = 3'd1,
      FC_ILLEGAL     = 3'd2,
      FC_SEQ         = 3'd3,
      FC_AMBER_SHORT = 3'd4
   } fault_code_e;

   typedef enum logic [1:0] {RED, AMBER, GREEN} lamp_e;

   typedef enum logic {ST_NORMAL, ST_FAULT} state_e;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (v[k]) idx = 3'(k);
      end
      return idx;
   endfunction

endpackage

// File: rtl/head_seq_checker.sv
// Per-head lamp checker: one-hot decode, R->G->A->R sequencing against the
// last accepted lamp, and minimum amber duration.
module head_seq_checker #(
   parameter int MIN_AMBER = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_upd,
   input  logic i_clr,
   input  logic i_r,
   input  logic i_a,
   input  logic i_g,
   output logic o_illegal,
   output logic o_seq_err,
   output logic o_amber_short,
   output logic o_non_red
);
   import traffic_pkg::*;

   localparam int CW = $clog2(MIN_AMBER + 1);

   lamp_e         r_prev;
   logic [CW-1:0] r_amber_cnt;
   lamp_e         w_cur;
   logic          w_onehot;

   always_comb begin
      w_onehot      = ({i_r, i_a, i_g} == 3'b100) || ({i_r, i_a, i_g} == 3'b010) ||
                      ({i_r, i_a, i_g} == 3'b001);
      w_cur         = i_g ? GREEN : (i_a ? AMBER : RED);
      o_illegal     = !w_onehot;
      o_non_red     = i_a | i_g;
      o_seq_err     = 1'b0;
      o_amber_short = 1'b0;
      if (w_onehot) begin
         case (r_prev)
            RED:     o_seq_err = (w_cur == AMBER);
            AMBER: begin
               o_seq_err     = (w_cur == GREEN);
               o_amber_short = (w_cur == RED) && (r_amber_cnt != CW'(MIN_AMBER));
            end
            GREEN:   o_seq_err = (w_cur == RED);
            default: o_seq_err = 1'b1;
         endcase
      end
   end

   // The counter holds the amber run length up to and including the last accepted cycle.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_prev      <= RED;
         r_amber_cnt <= '0;
      end else if (i_upd) begin
         r_prev <= w_cur;
         if (w_cur != AMBER)
            r_amber_cnt <= '0;
         else if (r_amber_cnt != CW'(MIN_AMBER))
            r_amber_cnt <= r_amber_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/junction_safety_monitor.sv
// Lamp-path safety monitor: registers controller lamps through to the drivers
// and drops to latched all-red flashing on any conflict or sequencing fault.
module junction_safety_monitor #(
   parameter int                           N_HEADS      = traffic_pkg::N_HEADS,
   parameter logic [N_HEADS*N_HEADS-1:0]   CONFLICT     = traffic_pkg::DEFAULT_CONFLICT,
   parameter int                           MIN_AMBER    = 4,
   parameter int                           FLASH_HALF   = 8,
   parameter int                           ALLRED_CLEAR = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_HEADS-1:0] r_in,
   input  logic [N_HEADS-1:0] a_in,
   input  logic [N_HEADS-1:0] g_in,
   input  logic               clear_fault,
   output logic [N_HEADS-1:0] r_out,
   output logic [N_HEADS-1:0] a_out,
   output logic [N_HEADS-1:0] g_out,
   output logic               fault,
   output logic [2:0]         fault_code,
   output logic [2:0]         fault_head
);
   import traffic_pkg::*;

   localparam int FW = $clog2(FLASH_HALF + 1);
   localparam int AW = $clog2(ALLRED_CLEAR + 1);

   state_e       r_state, w_state_nxt;
   fault_code_e  r_code, w_code_nxt, w_code;
   logic [2:0]   r_head, w_head_nxt, w_head;
   logic [FW-1:0] r_flash_cnt, w_flash_nxt;
   logic [AW-1:0] r_allred_cnt, w_allred_nxt;
   logic [N_HEADS-1:0] w_r_nxt, w_a_nxt, w_g_nxt;
   logic [N_HEADS-1:0] w_illegal, w_seq_err, w_amber_short, w_non_red, w_conf;
   logic         w_upd, w_clr, w_allred_in;

   for (genvar h = 0; h < N_HEADS; h++) begin : g_head
      head_seq_checker #(.MIN_AMBER(MIN_AMBER)) u_chk (
         .clk           (clk),
         .rst           (rst),
         .i_upd         (w_upd),
         .i_clr         (w_clr),
         .i_r           (r_in[h]),
         .i_a           (a_in[h]),
         .i_g           (g_in[h]),
         .o_illegal     (w_illegal[h]),
         .o_seq_err     (w_seq_err[h]),
         .o_amber_short (w_amber_short[h]),
         .o_non_red     (w_non_red[h])
      );
   end

   // Each offending pair is attributed to its lower-index head.
   always_comb begin
      w_conf = '0;
      for (int i = 0; i < N_HEADS; i++) begin
         for (int j = 0; j < N_HEADS; j++) begin
            if (CONFLICT[N_HEADS*i+j] && w_non_red[i] && w_non_red[j])
               w_conf[(i < j) ? i : j] = 1'b1;
         end
      end
   end

   always_comb begin
      w_code = FC_NONE;
      w_head = 3'd0;
      if (|w_conf) begin
         w_code = FC_CONFLICT;
         w_head = lowest_set(8'(w_conf));
      end else if (|w_illegal) begin
         w_code = FC_ILLEGAL;
         w_head = lowest_set(8'(w_illegal));
      end else if (|w_seq_err) begin
         w_code = FC_SEQ;
         w_head = lowest_set(8'(w_seq_err));
      end else if (|w_amber_short) begin
         w_code = FC_AMBER_SHORT;
         w_head = lowest_set(8'(w_amber_short));
      end
   end

   assign w_allred_in = (r_in == '1) && (a_in == '0) && (g_in == '0);

   always_comb begin
      w_state_nxt  = r_state;
      w_r_nxt      = r_out;
      w_a_nxt      = a_out;
      w_g_nxt      = g_out;
      w_code_nxt   = r_code;
      w_head_nxt   = r_head;
      w_flash_nxt  = r_flash_cnt;
      w_allred_nxt = r_allred_cnt;
      w_upd        = 1'b0;
      w_clr        = 1'b0;
      case (r_state)
         ST_NORMAL: begin
            if (w_code != FC_NONE) begin
               w_state_nxt  = ST_FAULT;
               w_r_nxt      = '1;
               w_a_nxt      = '0;
               w_g_nxt      = '0;
               w_code_nxt   = w_code;
               w_head_nxt   = w_head;
               w_flash_nxt  = '0;
               w_allred_nxt = '0;
            end else begin
               w_upd   = 1'b1;
               w_r_nxt = r_in;
               w_a_nxt = a_in;
               w_g_nxt = g_in;
            end
         end
         ST_FAULT: begin
            w_a_nxt = '0;
            w_g_nxt = '0;
            if (clear_fault && (r_allred_cnt == AW'(ALLRED_CLEAR))) begin
               w_state_nxt  = ST_NORMAL;
               w_r_nxt      = '1;
               w_code_nxt   = FC_NONE;
               w_head_nxt   = 3'd0;
               w_flash_nxt  = '0;
               w_allred_nxt = '0;
               w_clr        = 1'b1;
            end else begin
               if (r_flash_cnt == FW'(FLASH_HALF - 1)) begin
                  w_r_nxt     = ~r_out;
                  w_flash_nxt = '0;
               end else begin
                  w_flash_nxt = r_flash_cnt + FW'(1);
               end
               if (!w_allred_in)
                  w_allred_nxt = '0;
               else if (r_allred_cnt != AW'(ALLRED_CLEAR))
                  w_allred_nxt = r_allred_cnt + AW'(1);
            end
         end
         default: w_state_nxt = ST_NORMAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_NORMAL;
         r_out        <= '1;
         a_out        <= '0;
         g_out        <= '0;
         r_code       <= FC_NONE;
         r_head       <= 3'd0;
         r_flash_cnt  <= '0;
         r_allred_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_out        <= w_r_nxt;
         a_out        <= w_a_nxt;
         g_out        <= w_g_nxt;
         r_code       <= w_code_nxt;
         r_head       <= w_head_nxt;
         r_flash_cnt  <= w_flash_nxt;
         r_allred_cnt <= w_allred_nxt;
      end
   end

   assign fault      = (r_state == ST_FAULT);
   assign fault_code = r_code;
   assign fault_head = r_head;

endmodule

// File: tb/tb_junction_safety_monitor.sv
// Bench for junction_safety_monitor: directed lamp sequences, a rule-level
// reference model compared every cycle, and literal spot checks.
module tb_junction_safety_monitor;

   localparam int          MIN_AMBER    = 4;
   localparam int          FLASH_HALF   = 8;
   localparam int          ALLRED_CLEAR = 4;
   localparam logic [35:0] CONF         = 36'h3CFCF3F3C;
   localparam logic [1:0]  LR = 2'd0, LA = 2'd1, LG = 2'd2, LD = 2'd3;
   localparam logic [11:0] ALLR = 12'h000;

   logic       clk, rst, clear_fault;
   logic [5:0] r_in, a_in, g_in, r_out, a_out, g_out;
   logic       fault;
   logic [2:0] fault_code, fault_head;

   int n_cmp = 0;
   int n_err = 0;

   junction_safety_monitor dut (
      .clk(clk), .rst(rst), .r_in(r_in), .a_in(a_in), .g_in(g_in),
      .clear_fault(clear_fault), .r_out(r_out), .a_out(a_out), .g_out(g_out),
      .fault(fault), .fault_code(fault_code), .fault_head(fault_head)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: lamp per head as 0=R 1=A 2=G, -1 when not one-hot.
   bit         m_valid = 1'b0;
   bit         m_fault;
   int         m_prev[6], m_amb[6], m_k, m_allred;
   logic [5:0] e_r, e_a, e_g;
   int         e_code, e_head;

   function automatic bit legal_move(input int p, input int c);
      return (p == c) || (p == 0 && c == 2) || (p == 2 && c == 1) || (p == 1 && c == 0);
   endfunction

   task automatic model_reset();
      m_valid = 1'b1; m_fault = 1'b0; m_k = 0; m_allred = 0;
      for (int i = 0; i < 6; i++) begin m_prev[i] = 0; m_amb[i] = 0; end
      e_r = 6'h3F; e_a = 6'h00; e_g = 6'h00; e_code = 0; e_head = 0;
   endtask

   task automatic model_step();
      int cur[6];
      int conf_h, ill_h, seq_h, sh_h, code, head, lo;
      logic [5:0] nr;
      if (!m_fault) begin
         conf_h = -1; ill_h = -1; seq_h = -1; sh_h = -1;
         nr = a_in | g_in;
         for (int i = 0; i < 6; i++) begin
            case ({r_in[i], a_in[i], g_in[i]})
               3'b100:  cur[i] = 0;
               3'b010:  cur[i] = 1;
               3'b001:  cur[i] = 2;
               default: cur[i] = -1;
            endcase
         end
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
               if (CONF[6*i+j] && nr[i] && nr[j]) begin
                  lo = (i < j) ? i : j;
                  if (conf_h < 0 || lo < conf_h) conf_h = lo;
               end
         for (int i = 5; i >= 0; i--) begin
            if (cur[i] < 0) ill_h = i;
            else begin
               if (!legal_move(m_prev[i], cur[i])) seq_h = i;
               if (m_prev[i] == 1 && cur[i] == 0 && m_amb[i] < MIN_AMBER) sh_h = i;
            end
         end
         code = 0; head = 0;
         if (conf_h >= 0)      begin code = 1; head = conf_h; end
         else if (ill_h >= 0)  begin code = 2; head = ill_h; end
         else if (seq_h >= 0)  begin code = 3; head = seq_h; end
         else if (sh_h >= 0)   begin code = 4; head = sh_h; end
         if (code != 0) begin
            m_fault = 1'b1; m_k = 0; m_allred = 0;
            e_r = 6'h3F; e_a = 6'h00; e_g = 6'h00; e_code = code; e_head = head;
         end else begin
            e_r = r_in; e_a = a_in; e_g = g_in;
            for (int i = 0; i < 6; i++) begin
               m_amb[i]  = (cur[i] == 1) ? ((m_amb[i] + 1 > MIN_AMBER) ? MIN_AMBER : m_amb[i] + 1) : 0;
               m_prev[i] = cur[i];
            end
         end
      end else if (clear_fault && m_allred == ALLRED_CLEAR) begin
         model_reset();
      end else begin
         m_k++;
         e_r = ((m_k / FLASH_HALF) % 2 == 0) ? 6'h3F : 6'h00;
         e_a = 6'h00; e_g = 6'h00;
         if (r_in == 6'h3F && a_in == 6'h00 && g_in == 6'h00)
            m_allred = (m_allred + 1 > ALLRED_CLEAR) ? ALLRED_CLEAR : m_allred + 1;
         else
            m_allred = 0;
      end
   endtask

   always @(posedge clk) begin
      if (rst) model_reset();
      else if (m_valid) model_step();
      #2;
      if (m_valid) begin
         check("cyc_r_out", 32'(r_out), 32'(e_r));
         check("cyc_a_out", 32'(a_out), 32'(e_a));
         check("cyc_g_out", 32'(g_out), 32'(e_g));
         check("cyc_fault", 32'(fault), 32'(m_fault));
         check("cyc_code", 32'(fault_code), 32'(e_code));
         check("cyc_head", 32'(fault_head), 32'(e_head));
      end
   end

   function automatic logic [11:0] hl(input int h, input logic [1:0] lamp);
      logic [11:0] v;
      v = '0;
      v[2*h +: 2] = lamp;
      return v;
   endfunction

   task automatic drive_lamps(input logic [11:0] l);
      for (int i = 0; i < 6; i++) begin
         r_in[i] = (l[2*i +: 2] == LR);
         a_in[i] = (l[2*i +: 2] == LA);
         g_in[i] = (l[2*i +: 2] == LG);
      end
   endtask

   task automatic step(input logic [11:0] l, input logic clr);
      @(negedge clk);
      rst = 1'b0;
      drive_lamps(l);
      clear_fault = clr;
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_lamps(ALLR);
      clear_fault = 1'b0;
      @(posedge clk);
      #3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; clear_fault = 1'b0;
      drive_lamps(ALLR);
      repeat (2) @(posedge clk);
      #3;
      check("rst_r_out", 32'(r_out), 32'h3F);
      check("rst_g_out", 32'(g_out), 32'h00);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_code", 32'(fault_code), 32'h0);

      // Legal G5/A4/R on heads 0 and 1.
      step(hl(0, LG) | hl(1, LG), 1'b0);
      check("legal_g_out", 32'(g_out), 32'h03);
      check("legal_r_out", 32'(r_out), 32'h3C);
      repeat (4) step(hl(0, LG) | hl(1, LG), 1'b0);
      repeat (4) step(hl(0, LA) | hl(1, LA), 1'b0);
      check("legal_a_out", 32'(a_out), 32'h03);
      step(ALLR, 1'b0);
      check("legal_fault", 32'(fault), 32'h0);
      check("legal_back_red", 32'(r_out), 32'h3F);

      // Conflict 0/2, then ignored and accepted clears.
      step(hl(0, LG) | hl(2, LG), 1'b0);
      check("conf_fault", 32'(fault), 32'h1);
      check("conf_code", 32'(fault_code), 32'h1);
      check("conf_head", 32'(fault_head), 32'h0);
      check("conf_g_out", 32'(g_out), 32'h00);
      check("conf_r_out", 32'(r_out), 32'h3F);
      repeat (2) step(ALLR, 1'b0);
      step(ALLR, 1'b1);
      check("clear_early_ignored", 32'(fault), 32'h1);
      step(ALLR, 1'b0);
      check("clear_not_remembered", 32'(fault), 32'h1);
      step(ALLR, 1'b1);
      check("clear_fault", 32'(fault), 32'h0);
      check("clear_code", 32'(fault_code), 32'h0);
      step(hl(0, LG), 1'b0);
      check("resume_g_out", 32'(g_out), 32'h01);

      // Short amber on head 4, then the minimum legal amber.
      do_reset();
      repeat (2) step(hl(4, LG), 1'b0);
      repeat (3) step(hl(4, LA), 1'b0);
      step(ALLR, 1'b0);
      check("short_code", 32'(fault_code), 32'h4);
      check("short_head", 32'(fault_head), 32'h4);
      do_reset();
      repeat (2) step(hl(4, LG), 1'b0);
      repeat (4) step(hl(4, LA), 1'b0);
      step(ALLR, 1'b0);
      check("amber4_fault", 32'(fault), 32'h0);

      // G->R on head 3, flash timing, reset mid-flash.
      do_reset();
      step(hl(3, LG), 1'b0);
      step(ALLR, 1'b0);
      check("seq_code", 32'(fault_code), 32'h3);
      check("seq_head", 32'(fault_head), 32'h3);
      for (int n = 1; n <= 24; n++) begin
         step(ALLR, 1'b0);
         if (n == 7)  check("flash_n7", 32'(r_out), 32'h3F);
         if (n == 8)  check("flash_n8", 32'(r_out), 32'h00);
         if (n == 16) check("flash_n16", 32'(r_out), 32'h3F);
         if (n == 24) check("flash_n24", 32'(r_out), 32'h00);
      end
      do_reset();
      check("midflash_rst_r_out", 32'(r_out), 32'h3F);
      check("midflash_rst_fault", 32'(fault), 32'h0);
      step(hl(0, LG), 1'b0);
      check("post_rst_g_out", 32'(g_out), 32'h01);
      check("post_rst_fault", 32'(fault), 32'h0);

      // Dark head, and conflict outranking a simultaneous sequence error.
      do_reset();
      step(hl(0, LG) | hl(1, LG) | hl(2, LD), 1'b0);
      check("dark_code", 32'(fault_code), 32'h2);
      check("dark_head", 32'(fault_head), 32'h2);
      do_reset();
      step(hl(1, LG) | hl(5, LG) | hl(3, LA), 1'b0);
      check("prio_code", 32'(fault_code), 32'h1);
      check("prio_head", 32'(fault_head), 32'h1);
      step(ALLR, 1'b0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
